alu_issue_seq: RTL and testbench

- Initiator side of the ALU operand interface. It accepts one operation request per handshake from decode/control (op, two operands, tag).
- It drives the ALU op/x/y inputs, holds them stable for the ALU latency, and captures the ALU result w.
- It presents the captured result downstream with a valid/ready handshake.
- It sits between the decode stage and the ALU, and owns all ALU input sequencing.

---
 rtl/alu_issue_seq.sv | 91 +++++++++
 tb/tb_alu_issue_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// ALU operand sequencer: takes one request per handshake, holds the ALU inputs for
// ALU_LAT edges, captures w and presents it downstream with valid/ready.
module alu_issue_seq #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 7,
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  state_t             state_reg;
  logic [3:0]         lat_cnt_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               accept;

  // DONE can hand over to a new request in the same edge the result is consumed.
  assign in_ready = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      tag_reg     <= '0;
      alu_op      <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      out_result  <= '0;
      out_tag     <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        WAIT: begin
          if (lat_cnt_reg != 4'd0) begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end else begin
            out_result <= alu_w;
            out_tag    <= tag_reg;
            out_valid  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Shared load path for both IDLE and back-to-back DONE acceptance.
      if (accept) begin
        alu_op      <= in_op;
        alu_x       <= in_x;
        alu_y       <= in_y;
        tag_reg     <= in_tag;
        lat_cnt_reg <= LAT_INIT;
        state_reg   <= WAIT;
        busy        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: two instances (ALU_LAT=1 and ALU_LAT=3), each with a pipelined ALU stub.
module tb_alu_issue_seq;
  localparam int DATA_W = 32;
  localparam int OP_W   = 7;
  localparam int TAG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 7'd0;
  localparam logic [OP_W-1:0] OP_SUB = 7'd1;
  localparam logic [OP_W-1:0] OP_AND = 7'd2;
  localparam logic [OP_W-1:0] OP_OR  = 7'd3;
  localparam logic [OP_W-1:0] OP_XOR = 7'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst        [2];
  logic              in_valid   [2];
  logic              in_ready   [2];
  logic [OP_W-1:0]   in_op      [2];
  logic [DATA_W-1:0] in_x       [2];
  logic [DATA_W-1:0] in_y       [2];
  logic [TAG_W-1:0]  in_tag     [2];
  logic [OP_W-1:0]   alu_op     [2];
  logic [DATA_W-1:0] alu_x      [2];
  logic [DATA_W-1:0] alu_y      [2];
  logic              out_valid  [2];
  logic              out_ready  [2];
  logic [DATA_W-1:0] out_result [2];
  logic [TAG_W-1:0]  out_tag    [2];
  logic              busy       [2];

  int vectors = 0;
  int miscompares = 0;

  // Behaviour of the external ALU; undefined opcodes get an arbitrary but fixed mix.
  function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y);
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~x ^ {y[15:0], y[31:16]} ^ {25'd0, op};
    endcase
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 1 : 3;
      localparam int PIDX = (L >= 2) ? L - 2 : 0;
      logic [DATA_W-1:0] alu_w;
      logic [OP_W+2*DATA_W-1:0] pipe [0:3];

      alu_issue_seq #(.DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .ALU_LAT(L)) dut (
        .clk(clk), .rst(rst[gi]),
        .in_valid(in_valid[gi]), .in_ready(in_ready[gi]),
        .in_op(in_op[gi]), .in_x(in_x[gi]), .in_y(in_y[gi]), .in_tag(in_tag[gi]),
        .alu_op(alu_op[gi]), .alu_x(alu_x[gi]), .alu_y(alu_y[gi]), .alu_w(alu_w),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
        .out_result(out_result[gi]), .out_tag(out_tag[gi]), .busy(busy[gi])
      );

      // ALU stub: result of the operands seen L-1 edges ago, combinational for L=1.
      always @(posedge clk) begin
        pipe[0] <= {alu_op[gi], alu_x[gi], alu_y[gi]};
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end

      always_comb begin
        logic [OP_W+2*DATA_W-1:0] v;
        v = (L == 1) ? {alu_op[gi], alu_x[gi], alu_y[gi]} : pipe[PIDX];
        alu_w = alu_ref(v[OP_W+2*DATA_W-1 -: OP_W], v[2*DATA_W-1 -: DATA_W], v[DATA_W-1:0]);
      end
    end
  endgenerate

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input int i, input string tag);
    check({tag, "_out_valid"}, out_valid[i], 0);
    check({tag, "_busy"}, busy[i], 0);
    check({tag, "_alu_op"}, alu_op[i], 0);
    check({tag, "_alu_x"}, alu_x[i], 0);
    check({tag, "_alu_y"}, alu_y[i], 0);
    check({tag, "_out_result"}, out_result[i], 0);
    check({tag, "_out_tag"}, out_tag[i], 0);
    check({tag, "_in_ready"}, in_ready[i], 1);
  endtask

  // Single request from IDLE, optional backpressure, spurious in_valid pulses while waiting.
  task automatic do_op(input int i, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] x,
                       input logic [DATA_W-1:0] y, input logic [TAG_W-1:0] tag, input int stall);
    logic [DATA_W-1:0] exp;
    int n;
    exp = alu_ref(op, x, y);
    check("idle_in_ready", in_ready[i], 1);
    out_ready[i] = 1'b0;
    in_valid[i] = 1'b1; in_op[i] = op; in_x[i] = x; in_y[i] = y; in_tag[i] = tag;
    tick;
    in_valid[i] = 1'b0; in_x[i] = 32'hDEAD; in_op[i] = 7'h55; in_tag[i] = ~tag;
    check("acc_alu_op", alu_op[i], op);
    check("acc_alu_x", alu_x[i], x);
    check("acc_alu_y", alu_y[i], y);
    check("acc_busy", busy[i], 1);
    check("acc_out_valid", out_valid[i], 0);
    n = 0;
    while (out_valid[i] !== 1'b1 && n < 40) begin
      check("wait_in_ready", in_ready[i], 0);
      in_valid[i] = 1'($urandom_range(0, 1));
      tick;
      n++;
      check("wait_alu_x", alu_x[i], x);
      check("wait_alu_y", alu_y[i], y);
      check("wait_busy", busy[i], 1);
    end
    in_valid[i] = 1'b0;
    check("latency", n, lat_of(i));
    check("result", out_result[i], exp);
    check("tag", out_tag[i], tag);
    for (int s = 0; s < stall; s++) begin
      tick;
      check("bp_out_valid", out_valid[i], 1);
      check("bp_result", out_result[i], exp);
      check("bp_tag", out_tag[i], tag);
      check("bp_in_ready", in_ready[i], 0);
    end
    out_ready[i] = 1'b1;
    #1;
    check("done_in_ready", in_ready[i], 1);
    tick;
    check("release_out_valid", out_valid[i], 0);
    check("release_busy", busy[i], 0);
    check("idle_hold_alu_x", alu_x[i], x);
    out_ready[i] = 1'b0;
    $display("lat=%0d op=%0h x=%h y=%h tag=%0h -> result=%h stall=%0d", lat_of(i), op, x, y,
             tag, out_result[i], stall);
  endtask

  // Back-to-back stream with out_ready tied high and in_valid held.
  task automatic b2b(input int i, input int cnt, input bit directed);
    logic [OP_W-1:0]   ops [16];
    logic [DATA_W-1:0] xs  [16];
    logic [DATA_W-1:0] ys  [16];
    logic [TAG_W-1:0]  tgs [16];
    logic [DATA_W-1:0] qres [$];
    logic [TAG_W-1:0]  qtag [$];
    int sent, got, cyc, last;
    bit acc;
    for (int k = 0; k < cnt; k++) begin
      ops[k] = 7'($urandom_range(0, 6));
      xs[k] = $urandom; ys[k] = $urandom; tgs[k] = 4'($urandom);
    end
    if (directed) begin
      ops[0] = OP_ADD; xs[0] = 32'h7FFF_FFFF; ys[0] = 32'h1; tgs[0] = 4'h1;
      ops[1] = OP_ADD; xs[1] = 32'hFFFF_FFFF; ys[1] = 32'h1; tgs[1] = 4'h2;
    end
    sent = 0; got = 0; cyc = 0; last = -1;
    out_ready[i] = 1'b1;
    in_valid[i] = 1'b1; in_op[i] = ops[0]; in_x[i] = xs[0]; in_y[i] = ys[0]; in_tag[i] = tgs[0];
    while (got < cnt && cyc < 200) begin
      acc = in_valid[i] & in_ready[i];
      tick;
      cyc++;
      if (acc) begin
        qres.push_back(alu_ref(in_op[i], in_x[i], in_y[i]));
        qtag.push_back(in_tag[i]);
        sent++;
        if (sent < cnt) begin
          in_op[i] = ops[sent]; in_x[i] = xs[sent]; in_y[i] = ys[sent]; in_tag[i] = tgs[sent];
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      if (out_valid[i] === 1'b1) begin
        if (qres.size() == 0) begin
          check("b2b_spurious", 1, 0);
        end else begin
          check("b2b_result", out_result[i], qres.pop_front());
          check("b2b_tag", out_tag[i], qtag.pop_front());
        end
        if (last >= 0) check("b2b_spacing", cyc - last, lat_of(i) + 1);
        $display("b2b lat=%0d result=%h tag=%0h cycle=%0d", lat_of(i), out_result[i],
                 out_tag[i], cyc);
        last = cyc;
        got++;
      end
    end
    check("b2b_count", got, cnt);
    if (directed) check("b2b_dir_last", out_result[i], 32'h0);
    tick;
    out_ready[i] = 1'b0;
    check("b2b_end_busy", busy[i], 0);
  endtask

  // Reset while a request is in flight: no result may ever surface.
  task automatic reset_mid(input int i, input bit in_done);
    in_valid[i] = 1'b1; in_op[i] = OP_ADD; in_x[i] = 32'h1; in_y[i] = 32'h2; in_tag[i] = 4'h3;
    out_ready[i] = 1'b0;
    tick;
    in_valid[i] = 1'b0;
    if (in_done) begin
      repeat (lat_of(i)) tick;
      check("rst_pre_out_valid", out_valid[i], 1);
    end
    rst[i] = 1'b1;
    tick;
    rst[i] = 1'b0;
    check_reset_state(i, in_done ? "rst_done" : "rst_wait");
    out_ready[i] = 1'b1;
    for (int k = 0; k < lat_of(i) + 3; k++) begin
      tick;
      check("rst_no_result", out_valid[i], 0);
    end
    out_ready[i] = 1'b0;
    $display("reset mid-op lat=%0d in_done=%0d", lat_of(i), in_done);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; in_op[i] = '0; in_x[i] = '0; in_y[i] = '0;
      in_tag[i] = '0; out_ready[i] = 1'b0;
    end
    repeat (3) tick;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_reset_state(0, "reset0");
    check_reset_state(1, "reset1");

    for (int i = 0; i < 2; i++) begin
      do_op(i, OP_ADD, 32'h1, 32'h2, 4'h5, 0);
      check("add_result", out_result[i], 32'h3);
      do_op(i, OP_ADD, 32'h1, 32'h2, 4'h5, 5);
      do_op(i, OP_ADD, 32'd10, 32'd20, 4'h9, 1);
      check("add_10_20", out_result[i], 32'd30);
      b2b(i, 2, 1'b1);
      reset_mid(i, 1'b0);
      reset_mid(i, 1'b1);

      rst[i] = 1'b1; in_valid[i] = 1'b1; in_x[i] = 32'h55;
      tick;
      rst[i] = 1'b0; in_valid[i] = 1'b0;
      check("rst_in_valid_busy", busy[i], 0);
      check("rst_in_valid_alu_x", alu_x[i], 0);

      for (int k = 0; k < 15; k++)
        do_op(i, 7'($urandom_range(0, 127)), $urandom, $urandom, 4'($urandom),
              int'($urandom_range(0, 3)));
      b2b(i, 6, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
